// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_if
// Brief    : Soft-reset handshake and reset-output bundle of reset_sequencer.
// Revision : 1.0
// ============================================================================
interface reset_sequencer_if #(
    parameter int NUM_OUT = 3
);
    logic               sw_rst_req;
    logic               sw_rst_ack;
    logic [NUM_OUT-1:0] rst_n_out;
    logic               rst_done;
    logic               busy;

    // master: the software requester and the consumer domains
    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  rst_n_out,
        input  rst_done,
        input  busy
    );

    // slave: the sequencer itself
    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output rst_n_out,
        output rst_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Synchronizes nrst release, holds reset, then releases NUM_OUT
//            staggered active-low resets; supports a four-phase soft reset.
// Revision : 1.0
// ============================================================================
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int NUM_OUT        = 3
) (
    input  logic              clk,
    input  logic              nrst,
    reset_sequencer_if.slave  bus
);

    localparam int c_max_cnt = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stag_last = c_cnt_w'(STAGGER_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_sequencer: HOLD_CYCLES must be >= 1");
        end
        if (STAGGER_CYCLES < 1) begin : g_bad_stagger
            $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
        end
        if (NUM_OUT < 1) begin : g_bad_num_out
            $error("reset_sequencer: NUM_OUT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SW_ACK  = 2'd3
    } state_t;

    state_t                   state_q,     state_d;
    logic [SYNC_STAGES-1:0]   sync_q,      sync_d;
    logic [c_cnt_w-1:0]       cnt_q,       cnt_d;
    logic [NUM_OUT-1:0]       rst_n_out_q, rst_n_out_d;
    logic                     rst_done_q,  rst_done_d;
    logic                     sw_rst_ack_q, sw_rst_ack_d;

    logic                     w_released;
    logic [NUM_OUT-1:0]       w_shifted;

    assign sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    assign w_released = sync_q[SYNC_STAGES-1];

    // Thermometer step: releases the next-lowest still-asserted output.
    assign w_shifted  = NUM_OUT'({rst_n_out_q, 1'b1});

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_HOLD;
            sync_q       <= '0;
            cnt_q        <= '0;
            rst_n_out_q  <= '0;
            rst_done_q   <= 1'b0;
            sw_rst_ack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            rst_n_out_q  <= rst_n_out_d;
            rst_done_q   <= rst_done_d;
            sw_rst_ack_q <= sw_rst_ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rst_n_out_d  = rst_n_out_q;
        rst_done_d   = rst_done_q;
        sw_rst_ack_d = sw_rst_ack_q;

        case (state_q)
            ST_HOLD: begin
                // Hold time only accrues once the synchronized release is seen.
                if (w_released) begin
                    if (cnt_q == c_hold_last) begin
                        cnt_d       = '0;
                        rst_n_out_d = w_shifted;
                        if (&w_shifted) begin
                            state_d    = ST_RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            state_d    = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
            end

            ST_RELEASE: begin
                if (cnt_q == c_stag_last) begin
                    cnt_d       = '0;
                    rst_n_out_d = w_shifted;
                    if (&w_shifted) begin
                        state_d    = ST_RUN;
                        rst_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_RUN: begin
                if (bus.sw_rst_req) begin
                    state_d      = ST_SW_ACK;
                    cnt_d        = '0;
                    rst_n_out_d  = '0;
                    rst_done_d   = 1'b0;
                    sw_rst_ack_d = 1'b1;
                end
            end

            ST_SW_ACK: begin
                // Sync chain stays high, so the hold restarts on the next edge.
                if (!bus.sw_rst_req) begin
                    state_d      = ST_HOLD;
                    cnt_d        = '0;
                    sw_rst_ack_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign bus.rst_n_out  = rst_n_out_q;
    assign bus.rst_done   = rst_done_q;
    assign bus.sw_rst_ack = sw_rst_ack_q;
    assign bus.busy       = (state_q != ST_RUN);

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Generates the active-low, synchronously released reset lines consumed by synchronous-reset flops (D flip-flops that clear on `!nrst` at `posedge clk`).
- Takes the board-level asynchronous `nrst`, synchronizes its deassertion and holds reset for a programmable time.
- Releases `NUM_OUT` downstream reset domains in staggered order.
- Supports a software-requested reset through a four-phase req/ack handshake.
- Sits at the top of each clock domain, between the reset pin and all consumer logic.

Parameters:
- SYNC_STAGES, 2: deassertion synchronizer depth; legal range >= 2.
- HOLD_CYCLES, 16: cycles reset is held after the synchronized release or after a soft-reset handshake completes; legal range >= 1.
- STAGGER_CYCLES, 4: cycles between successive output releases; legal range >= 1.
- NUM_OUT, 3: number of reset outputs; legal range >= 1.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- nrst, input, 1: asynchronous active-low reset; asserts all state immediately; deassertion is synchronized internally.
- sw_rst_req, input, 1: soft-reset request, level, four-phase.
- sw_rst_ack, output, 1: soft-reset acknowledge.
- rst_n_out, output, NUM_OUT: active-low resets to consumer domains; released synchronously, bit 0 first.
- rst_done, output, 1: high when all outputs are released and the block is in RUN.
- busy, output, 1: high in any state other than RUN.

Behaviour:
- Reset is decided: one clock `clk`; `nrst` is asynchronous and active-low. While `nrst` = 0, regardless of clock:
  - sync chain = 0, state = HOLD, counters = 0.
  - rst_n_out = 0, rst_done = 0, sw_rst_ack = 0, busy = 1.
- Synchronizer: SYNC_STAGES flops, asynchronously cleared by `nrst`, shifting in 1. Define E0 as the first posedge with `nrst` high. The last stage goes high after edge E(SYNC_STAGES-1).
- States: HOLD, RELEASE, RUN, SW_ACK.
- HOLD:
  - The counter increments only on edges where the synchronized release is high.
  - On the HOLD_CYCLES-th counted edge: set rst_n_out[0] = 1, clear the counter, go to RELEASE. If NUM_OUT = 1, go directly to RUN instead.
  - Power-on result: rst_n_out[0] rises after edge E(SYNC_STAGES+HOLD_CYCLES-1). With defaults this is E17.
- RELEASE:
  - Every STAGGER_CYCLES edges, the next index is set high.
  - rst_n_out[i] rises STAGGER_CYCLES*i edges after rst_n_out[0]. Defaults: E21 for bit 1, E25 for bit 2.
  - Once released, a bit stays high until the next reset event.
  - On the edge releasing bit NUM_OUT-1: go to RUN, and rst_done rises on that same edge.
- RUN:
  - rst_done = 1, busy = 0.
  - If sw_rst_req is sampled high at edge Ek: go to SW_ACK after Ek. At that point rst_n_out = all 0, rst_done = 0, sw_rst_ack = 1.
  - All outputs drop together; there is no stagger on assertion.
- SW_ACK:
  - sw_rst_ack held at 1 and outputs held low while sw_rst_req = 1.
  - On edge Em where sw_rst_req is sampled low: sw_rst_ack = 0, counter cleared, go to HOLD.
  - The sync chain is not cleared, so rst_n_out[0] rises after edge E(m+HOLD_CYCLES).
- sw_rst_req high in HOLD or RELEASE is ignored. If it is still high when RUN is reached, a new soft reset starts on the next edge (level-sensitive).
- The requester must not drop sw_rst_req before seeing sw_rst_ack. Dropping it earlier while in RUN simply means no request.
- `nrst` asserted mid-operation (any state, including SW_ACK and RELEASE): immediate asynchronous return to the reset values above. The full power-on sequence then restarts from the next deassertion.
- A glitch on `nrst` shorter than a clock still clears the sync chain. The release timing restarts from the edge after `nrst` returns high.
- Counter widths: $clog2 of max(HOLD_CYCLES, STAGGER_CYCLES)+1. No wrap is possible; the counter is cleared on every state change.
- rst_n_out, rst_done and sw_rst_ack are driven directly from flops; there is no combinational path from inputs to outputs.

Test Plan:
- Power-on, defaults: hold `nrst` = 0 for 5 cycles, then release between edges → rst_n_out = 000 until E17; 001 after E17, 011 after E21, 111 after E25; rst_done rises with E25; busy falls at E25.
- Mid-sequence reset: assert `nrst` = 0 at E20, off clock edge → rst_n_out = 000 and busy = 1 immediately, with no clock edge. Release again → same E17/E21/E25 timing relative to the new E0.
- Soft reset: in RUN, set sw_rst_req = 1 before edge Ek → after Ek, rst_n_out = 000, sw_rst_ack = 1. Hold req for 6 cycles, drop it before Em → ack = 0 after Em; rst_n_out = 001 after E(m+16), 011 after E(m+20), 111 after E(m+24).
- Request outside RUN: sw_rst_req = 1 continuously from E3 of power-on → no effect until RUN at E25; enters SW_ACK after E26 with ack = 1.
- `nrst` during SW_ACK: with ack = 1, assert `nrst` → ack = 0, outputs 000 asynchronously; after release, a full power-on sequence runs and req is honoured again only after RUN.
- Parameter corner: NUM_OUT = 1, HOLD_CYCLES = 1, SYNC_STAGES = 3 → rst_n_out[0] and rst_done rise together after E3; RELEASE is never entered.
